// File: rtl/anubis_pkg.sv
// Shared Anubis round-stage definitions: state geometry and the element
// packing helper used by every stage that addresses individual bytes.
package anubis_pkg;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned DW = N * N * W;

  // MSB bit index of element (r,c) in a row-major, MSB-first packed matrix.
  function automatic int unsigned elem_msb(input int unsigned n, input int unsigned w,
                                           input int unsigned r, input int unsigned c);
    return n * n * w - 1 - w * (n * r + c);
  endfunction

endpackage

// File: rtl/tau_core.sv
// Combinational tau: out element (r,c) = in element (c,r).
module tau_core import anubis_pkg::*; #(
  parameter int unsigned N = anubis_pkg::N,
  parameter int unsigned W = anubis_pkg::W
) (
  input  logic [N*N*W-1:0] in_data,
  output logic [N*N*W-1:0] out_data
);

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign out_data[elem_msb(N, W, r, c) -: W] = in_data[elem_msb(N, W, c, r) -: W];
    end
  end

endmodule

// File: rtl/tau_transpose.sv
// Anubis tau step: registered transpose behind a 2-entry skid buffer so it can
// sit between other pipelined round stages with a registered in_ready.
module tau_transpose import anubis_pkg::*; #(
  parameter int unsigned N = anubis_pkg::N,
  parameter int unsigned W = anubis_pkg::W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] out_data
);

  localparam int unsigned DW = N * N * W;

  logic [DW-1:0] xposed;
  logic [DW-1:0] skid_data, skid_data_nx, out_data_nx;
  logic          skid_valid, skid_valid_nx, out_valid_nx;
  logic          in_fire;

  tau_core #(.N(N), .W(W)) u_core (
    .in_data  (in_data),
    .out_data (xposed)
  );

  // The skid slot is only ever occupied while the main register is full, and
  // in_ready is low whenever it is occupied, so no input can arrive then.
  always_comb begin
    in_fire       = in_valid && in_ready;
    out_valid_nx  = out_valid;
    out_data_nx   = out_data;
    skid_valid_nx = skid_valid;
    skid_data_nx  = skid_data;
    if (skid_valid) begin
      if (out_ready) begin
        out_data_nx   = skid_data;
        skid_valid_nx = 1'b0;
      end
    end else if (!out_valid || out_ready) begin
      out_valid_nx = in_fire;
      if (in_fire) out_data_nx = xposed;
    end else if (in_fire) begin
      skid_valid_nx = 1'b1;
      skid_data_nx  = xposed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      out_valid  <= out_valid_nx;
      out_data   <= out_data_nx;
      skid_valid <= skid_valid_nx;
      skid_data  <= skid_data_nx;
      in_ready   <= !skid_valid_nx;
    end
  end

endmodule

// File: tb/tb_tau_transpose.sv
// Scoreboard bench for tau_transpose: expected words are queued on input
// transfer and compared in order as the DUT hands words downstream.
module tb_tau_transpose;

  localparam logic [127:0] REF   = 128'h01020304050607080910111213141516;
  localparam logic [127:0] REF_T = 128'h01050913020610140307111504081216;
  localparam logic [127:0] DIAG  = 128'h01000000000200000000030000000004;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned n_out = 0;
  int unsigned first_cyc = 0;
  int unsigned last_cyc = 0;
  logic [127:0] sb[$];
  logic [127:0] held;
  logic [127:0] bp_words[4];

  tau_transpose #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] tr(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[127-8*(4*r+c) -: 8] = x[127-8*(4*c+r) -: 8];
    return y;
  endfunction

  // Called just after a rising edge; returns just after the transfer edge.
  task automatic send(input logic [127:0] d, input logic [127:0] exp);
    int unsigned tries;
    in_valid = 1'b1;
    in_data  = d;
    tries    = 0;
    while (!in_ready && tries < 50) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {127'b0, in_ready}, 128'd1);
      in_valid = 1'b0;
    end else begin
      sb.push_back(exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", 128'(sb.size()), 128'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {127'b0, out_valid}, 128'd0);
      end else begin
        check("out_data", out_data, sb.pop_front());
        if (n_out == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_out++;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {127'b0, in_ready}, 128'd1);
    @(posedge clk); #1;

    send(REF, REF_T);
    check("ref_latency_valid", {127'b0, out_valid}, 128'd1);
    check("ref_latency_data", out_data, REF_T);
    send(DIAG, DIAG);
    send('0, '0);
    send('1, '1);
    send(REF_T, REF);
    drain();

    // Backpressure: two words fill main+skid, the rest wait for in_ready.
    for (int i = 0; i < 4; i++) bp_words[i] = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp_words[i], tr(bp_words[i]));
      end
      begin
        for (int k = 0; k < 50 && sb.size() < 2; k++) @(negedge clk);
        @(negedge clk);
        check("bp_in_ready_low", {127'b0, in_ready}, 128'd0);
        check("bp_first_word", out_data, tr(bp_words[0]));
        held = out_data;
        repeat (3) begin
          @(negedge clk);
          check("bp_hold", out_data, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_in_ready_high", {127'b0, in_ready}, 128'd1);
      end
    join
    drain();

    // Full-rate random streaming.
    n_out = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      logic [127:0] v;
      v = {$urandom, $urandom, $urandom, $urandom};
      send(v, tr(v));
    end
    drain();
    check("rand_count", 128'(n_out), 128'd16);
    check("rand_rate", 128'(last_cyc - first_cyc), 128'd15);

    // Reset with main and skid both occupied.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(REF, REF_T);
    send(DIAG, DIAG);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {127'b0, out_valid}, 128'd0);
    check("midrst_out_data", out_data, 128'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    out_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {127'b0, in_ready}, 128'd1);
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_stale", {127'b0, out_valid}, 128'd0);
    end
    @(posedge clk); #1;
    send(REF_T, REF);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tau_transpose.md
Name: tau_transpose

Overview:
- Anubis round-function step tau: transposes a 4x4 byte state matrix.
- Output byte (r,c) equals input byte (c,r).
- Registered and stream-handshaked so it can sit between other pipelined round stages: key-schedule stage, gamma, theta, sigma.
- Tau is an involution, so the same block serves encryption and decryption.

Parameters:
- N, 4, matrix dimension (rows = columns); Anubis requires 4.
- W, 8, element width in bits.
- Data width is DW = N*N*W (128 at defaults).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept input this cycle; registered output.
- in_data  input  DW  state matrix.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DW  transposed matrix; registered.

Behaviour:
- Packing: row-major, MSB first. Element (r,c) occupies bits [DW-1-W*(N*r+c) -: W]. At defaults, byte 0 (bits 127:120) is (0,0), bits 119:112 is (0,1), and bits 7:0 is (3,3).
- Transform (purely combinational core): out element (r,c) = in element (c,r).
  - Diagonal elements pass unchanged.
  - Applying the transform twice returns the original.
  - Example: 0x01020304050607080910111213141516 -> 0x01050913020610140307111504081216.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_data is sampled only on an input transfer. in_data is don't-care when in_valid=0.
- Storage: a 2-entry skid buffer.
  - A main output register drives out_data.
  - A skid register captures one extra word when the main register is full and not draining.
  - in_ready is registered: in_ready = skid register empty.
- Latency: 1 cycle. A word accepted at edge k appears on out_valid/out_data after edge k, provided the output is empty or draining.
- Throughput: 1 word/cycle while out_ready=1.
- Ordering: strictly FIFO, no drops, no duplicates.
- Stall rules:
  - While out_valid=1 and out_ready=0, out_data is held stable.
  - A word arriving during a stall goes to the skid register, and in_ready drops on the next cycle.
  - When out_ready returns, the skid word moves to the main register on the next edge and in_ready rises again.
- Simultaneous accept and drain with the main register full and the skid register empty: the main register loads the new transposed word directly and the skid register stays empty.
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, skid register empty and cleared.
  - in_ready=1 from the first edge after release.
  - Reset mid-stream discards all held words.
- No other state and no error outputs.

Decomposition:
- Shared package anubis_pkg holds N, W, DW and a function mapping (r,c) to a bit offset. The same function is reused by other round stages.
- One natural sub-module, tau_core: combinational, generate-loop transpose of DW bits.
- tau_transpose = tau_core plus skid-buffer control.

Test Plan:
- Reference vector with out_ready=1: in 0x01020304050607080910111213141516 -> out 0x01050913020610140307111504081216 one cycle later.
- Diagonal matrix 0x01000000000200000000030000000004 -> identical output. All-zero and all-FF vectors -> unchanged.
- Involution: feed the output of the reference vector back in -> 0x01020304050607080910111213141516.
- Backpressure: stream 4 words with out_ready=0 for 3 cycles. Required: in_ready falls after the 2nd word is held, out_data stays stable, then all 4 words emerge in order with no loss.
- Back-to-back streaming of 16 random vectors at full rate, checked against a software transpose. Required: one output per cycle, order preserved.
- Assert rst_n mid-stream with words buffered -> out_valid=0 and out_data=0 immediately; in_ready=1 after release; no stale word is emitted.
